// File: rtl/poly_pkg.sv
// Shared constants and the signed saturation helper for the polynomial evaluator.
package poly_pkg;

    localparam int ORDER_MAX = 4;

    // Working width wide enough to hold any full-width Horner product plus a coefficient.
    localparam int SAT_W = 64;

    // Coefficient values restored on reset, indexed by power of x.
    localparam int COEF_DEF [0:ORDER_MAX] = '{-3, 3, -4, 0, 0};

    // Clamp v into the m-bit signed range; clip reports whether clamping occurred.
    function automatic logic signed [SAT_W-1:0] sat(
        input  logic signed [SAT_W-1:0] v,
        input  int                      m,
        output logic                    clip
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi   = (64'sd1 <<< (m - 1)) - 64'sd1;
        lo   = -hi - 64'sd1;
        clip = 1'b0;
        if (v > hi) begin
            clip = 1'b1;
            return hi;
        end
        if (v < lo) begin
            clip = 1'b1;
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/poly_eval_pipe_if.sv
// Sample stream, result stream and coefficient-write port of the polynomial evaluator.
interface poly_eval_pipe_if #(
    parameter int WL = 15
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [WL-1:0] x;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [WL:0]   y;
    logic                 out_sat;
    logic                 coef_we;
    logic [2:0]           coef_addr;
    logic signed [WL-1:0] coef_wdata;
    logic                 busy;

    // Source/consumer side.
    modport master (
        output in_valid, x, out_ready, coef_we, coef_addr, coef_wdata,
        input  in_ready, out_valid, y, out_sat, busy
    );

    // Evaluator side.
    modport slave (
        input  in_valid, x, out_ready, coef_we, coef_addr, coef_wdata,
        output in_ready, out_valid, y, out_sat, busy
    );
endinterface

// File: rtl/poly_horner_stage.sv
// One Horner step: acc_out = sat(acc_in * x_in + coef), registered, with x and flags carried along.
module poly_horner_stage
    import poly_pkg::*;
#(
    parameter int WL    = 15,
    parameter int ACC_W = 2 * WL
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    en,
    input  logic                    vld_in,
    input  logic                    sat_in,
    input  logic signed [ACC_W-1:0] acc_in,
    input  logic signed [WL-1:0]    x_in,
    input  logic signed [WL-1:0]    coef,
    output logic signed [ACC_W-1:0] acc_out,
    output logic signed [WL-1:0]    x_out,
    output logic                    sat_out,
    output logic                    vld_out
);
    localparam int PW = ACC_W + WL;

    logic signed [PW-1:0]    prod;
    logic signed [SAT_W-1:0] sum;
    logic signed [ACC_W-1:0] acc_next;
    logic                    clip;

    // Full-width product plus coefficient, then clamp back into the accumulator range.
    always_comb begin
        prod     = PW'(acc_in) * PW'(x_in);
        sum      = SAT_W'(prod) + SAT_W'(coef);
        acc_next = ACC_W'(sat(sum, ACC_W, clip));
    end

    // Slice register; bubbles advance exactly like samples so ordering is preserved.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc_out <= '0;
            x_out   <= '0;
            sat_out <= 1'b0;
            vld_out <= 1'b0;
        end else if (en) begin
            acc_out <= acc_next;
            x_out   <= x_in;
            sat_out <= sat_in | clip;
            vld_out <= vld_in;
        end
    end
endmodule

// File: rtl/poly_eval_pipe.sv
// Pipelined Horner polynomial evaluator with programmable coefficients and valid/ready flow.
module poly_eval_pipe
    import poly_pkg::*;
#(
    parameter int WL    = 15,
    parameter int ORDER = 2,
    parameter int ACC_W = 2 * WL
) (
    input  logic           CLK,
    input  logic           RST_N,
    poly_eval_pipe_if.slave bus
);
    if (ORDER < 1 || ORDER > ORDER_MAX) begin : g_bad_order
        $error("poly_eval_pipe: ORDER must lie within 1..4");
    end

    logic signed [WL-1:0]    coef_r [0:ORDER];
    logic signed [ACC_W-1:0] acc_p  [0:ORDER];
    logic signed [WL-1:0]    x_p    [0:ORDER];
    logic                    sat_p  [0:ORDER];
    logic                    vld_p  [0:ORDER];

    logic signed [ACC_W-1:0] acc_p0;
    logic signed [WL-1:0]    x_p0;
    logic                    vld_p0;

    logic                    out_valid_r;
    logic signed [WL:0]      y_r;
    logic                    out_sat_r;
    logic signed [WL:0]      y_next;
    logic                    y_clip;

    logic                    en;
    logic                    any_vld;
    logic                    wr_take;
    logic                    in_ready_w;
    logic                    accept;
    logic signed [WL-1:0]    unused_x_last;

    // Whole pipeline moves as one; a pending coefficient write steals the input slot.
    assign en         = !out_valid_r || bus.out_ready;
    assign wr_take    = bus.coef_we && !any_vld;
    assign in_ready_w = en && !wr_take;
    assign accept     = bus.in_valid && in_ready_w;

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_r;
    assign bus.y         = y_r;
    assign bus.out_sat   = out_sat_r;
    assign bus.busy      = any_vld;

    // Busy whenever any stage register, including the output, holds a sample.
    always_comb begin
        any_vld = out_valid_r;
        for (int i = 0; i <= ORDER; i++) begin
            any_vld = any_vld | vld_p[i];
        end
    end

    // Coefficient file: writes land only while the pipeline is empty and the index is in range.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i <= ORDER; i++) begin
                coef_r[i] <= WL'(COEF_DEF[i]);
            end
        end else if (wr_take) begin
            for (int i = 0; i <= ORDER; i++) begin
                if (bus.coef_addr == 3'(i)) begin
                    coef_r[i] <= bus.coef_wdata;
                end
            end
        end
    end

    // ---- stage 0: capture x and seed the accumulator with the leading coefficient ----
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc_p0 <= '0;
            x_p0   <= '0;
            vld_p0 <= 1'b0;
        end else if (en) begin
            acc_p0 <= ACC_W'(coef_r[ORDER]);
            x_p0   <= bus.x;
            vld_p0 <= accept;
        end
    end

    assign acc_p[0] = acc_p0;
    assign x_p[0]   = x_p0;
    assign sat_p[0] = 1'b0;
    assign vld_p[0] = vld_p0;

    // ---- stages 1..ORDER: one Horner step each, lower coefficients further down ----
    for (genvar k = 1; k <= ORDER; k++) begin : g_stage
        poly_horner_stage #(
            .WL    (WL),
            .ACC_W (ACC_W)
        ) u_stage (
            .CLK     (CLK),
            .RST_N   (RST_N),
            .en      (en),
            .vld_in  (vld_p[k-1]),
            .sat_in  (sat_p[k-1]),
            .acc_in  (acc_p[k-1]),
            .x_in    (x_p[k-1]),
            .coef    (coef_r[ORDER-k]),
            .acc_out (acc_p[k]),
            .x_out   (x_p[k]),
            .sat_out (sat_p[k]),
            .vld_out (vld_p[k])
        );
    end

    // The last stage's x copy has no consumer.
    assign unused_x_last = x_p[ORDER];

    // ---- output stage: narrow the accumulator to WL+1 bits ----
    always_comb begin
        y_next = (WL + 1)'(sat(SAT_W'(acc_p[ORDER]), WL + 1, y_clip));
    end

    // Output register holds steady while the consumer stalls.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid_r <= 1'b0;
            y_r         <= '0;
            out_sat_r   <= 1'b0;
        end else if (en) begin
            out_valid_r <= vld_p[ORDER];
            y_r         <= y_next;
            out_sat_r   <= sat_p[ORDER] | y_clip;
        end
    end
endmodule

// File: tb/tb_poly_eval_pipe.sv
// Self-checking bench for poly_eval_pipe: an ORDER=2/WL=15 instance and an ORDER=4/WL=8 instance.
module tb_poly_eval_pipe;
    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   ecount = 0;
    int   rel_edge = 0;

    poly_eval_pipe_if #(.WL(15)) if2 ();
    poly_eval_pipe_if #(.WL(8))  if4 ();

    poly_eval_pipe #(.WL(15), .ORDER(2), .ACC_W(30)) dut2 (.CLK(CLK), .RST_N(RST_N), .bus(if2));
    poly_eval_pipe #(.WL(8),  .ORDER(4), .ACC_W(16)) dut4 (.CLK(CLK), .RST_N(RST_N), .bus(if4));

    initial forever #5 CLK = ~CLK;
    always @(posedge CLK) ecount <= ecount + 1;

    int  stim_x[$];
    int  cap_y[$];
    bit  cap_sat[$];
    int  cap_edge[$];
    int  acc_edge[$];
    int  stall_y[$];
    bit  stall_ir[$];
    int  exp_y[$];
    bit  exp_s[$];
    bit  drv_timeout;
    int  mc2 [0:4];
    int  mc4 [0:4];

    // Reference: Horner evaluation on plain integers with clamping after every step.
    function automatic void ref_eval(input int xv, input int cf[0:4], input int order, input int wl,
                                     output int yv, output bit sv);
        longint acc, amax, amin, ymax, ymin;
        amax = (longint'(1) <<< (2 * wl - 1)) - 1;
        amin = -amax - 1;
        ymax = (longint'(1) <<< wl) - 1;
        ymin = -ymax - 1;
        sv   = 1'b0;
        acc  = cf[order];
        for (int k = 1; k <= order; k++) begin
            acc = acc * xv + cf[order - k];
            if (acc > amax) begin acc = amax; sv = 1'b1; end
            else if (acc < amin) begin acc = amin; sv = 1'b1; end
        end
        if (acc > ymax) begin acc = ymax; sv = 1'b1; end
        else if (acc < ymin) begin acc = ymin; sv = 1'b1; end
        yv = int'(acc);
    endfunction

    task automatic set_defaults();
        mc2 = '{-3, 3, -4, 0, 0};
        mc4 = '{-3, 3, -4, 0, 0};
    endtask

    task automatic set_in(input int sel, input bit v, input int xv, input bit rdy);
        if (sel == 2) begin if2.in_valid = v; if2.x = 15'(xv); if2.out_ready = rdy; end
        else          begin if4.in_valid = v; if4.x = 8'(xv);  if4.out_ready = rdy; end
    endtask

    task automatic get_out(input int sel, output logic ov, output logic ir, output logic signed [31:0] yv,
                           output logic sv, output logic bz);
        if (sel == 2) begin
            ov = if2.out_valid; ir = if2.in_ready; yv = 32'($signed(if2.y)); sv = if2.out_sat; bz = if2.busy;
        end else begin
            ov = if4.out_valid; ir = if4.in_ready; yv = 32'($signed(if4.y)); sv = if4.out_sat; bz = if4.busy;
        end
    endtask

    task automatic write_coef(input int sel, input int addr, input int val);
        if (sel == 2) begin if2.coef_we = 1'b1; if2.coef_addr = 3'(addr); if2.coef_wdata = 15'(val); end
        else          begin if4.coef_we = 1'b1; if4.coef_addr = 3'(addr); if4.coef_wdata = 8'(val);  end
        @(posedge CLK); #1;
        if2.coef_we = 1'b0;
        if4.coef_we = 1'b0;
        if (sel == 2 && addr <= 2) mc2[addr] = val;
        if (sel == 4 && addr <= 4) mc4[addr] = val;
    endtask

    // Streams stim_x into one instance and records every completed output handshake.
    task automatic drive(input int sel, input int stall_len, input bit rand_ready);
        int idx = 0;
        int n = stim_x.size();
        int cyc = 0;
        int stalled = 0;
        int budget = 40 * n + 100;
        logic ov, ir, sv, bz;
        logic signed [31:0] yv;
        bit rdy;
        cap_y.delete(); cap_sat.delete(); cap_edge.delete(); acc_edge.delete();
        stall_y.delete(); stall_ir.delete();
        drv_timeout = 1'b0;
        while ((idx < n || cap_y.size() < n) && cyc < budget) begin
            get_out(sel, ov, ir, yv, sv, bz);
            if (ov && stalled < stall_len) begin rdy = 1'b0; stalled++; end
            else if (rand_ready) rdy = ($urandom_range(0, 3) != 0);
            else rdy = 1'b1;
            set_in(sel, idx < n, (idx < n) ? stim_x[idx] : 0, rdy);
            #1;
            get_out(sel, ov, ir, yv, sv, bz);
            if (ov && !rdy) begin stall_y.push_back(int'(yv)); stall_ir.push_back(ir); end
            if (ov && rdy) begin cap_y.push_back(int'(yv)); cap_sat.push_back(sv); cap_edge.push_back(ecount); end
            if (idx < n && ir) begin acc_edge.push_back(ecount + 1); idx++; end
            @(posedge CLK); #1;
            cyc++;
        end
        set_in(sel, 1'b0, 0, 1'b1);
        if (cyc >= budget) drv_timeout = 1'b1;
    endtask

    task automatic test_reset();
        logic ov, ir, sv, bz;
        logic signed [31:0] yv;
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        for (int s = 2; s <= 4; s += 2) begin
            get_out(s, ov, ir, yv, sv, bz);
            total++; if (ov !== 1'b0) begin bad++; $display("FAIL reset_out_valid dut%0d got=%b want=0", s, ov); end
            total++; if (bz !== 1'b0) begin bad++; $display("FAIL reset_busy dut%0d got=%b want=0", s, bz); end
            total++; if (yv !== 0)    begin bad++; $display("FAIL reset_y dut%0d got=%0d want=0", s, yv); end
            total++; if (sv !== 1'b0) begin bad++; $display("FAIL reset_sat dut%0d got=%b want=0", s, sv); end
            total++; if (ir !== 1'b1) begin bad++; $display("FAIL reset_in_ready dut%0d got=%b want=1", s, ir); end
        end
        RST_N = 1'b1;
        rel_edge = ecount;
    endtask

    task automatic test_defaults();
        int ey[3] = '{-13, -3, -10};
        int got;
        stim_x = '{2, 0, -1};
        drive(2, 0, 1'b0);
        total++; if (drv_timeout) begin bad++; $display("FAIL defaults_timeout got=%0d want=3 outputs", cap_y.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < cap_y.size()) ? cap_y[i] : 99999;
            total++; if (got !== ey[i]) begin bad++; $display("FAIL defaults_y[%0d] got=%0d want=%0d", i, got, ey[i]); end
            total++; if (i < cap_sat.size() && cap_sat[i] !== 1'b0) begin bad++; $display("FAIL defaults_sat[%0d] got=1 want=0", i); end
        end
        if (cap_edge.size() == 3 && acc_edge.size() == 3) begin
            total++; if (acc_edge[0] !== rel_edge + 1) begin bad++; $display("FAIL first_accept_edge got=%0d want=%0d", acc_edge[0], rel_edge + 1); end
            total++; if (cap_edge[0] - acc_edge[0] !== 3) begin bad++; $display("FAIL latency2 got=%0d want=3", cap_edge[0] - acc_edge[0]); end
            total++; if (cap_edge[2] - cap_edge[0] !== 2) begin bad++; $display("FAIL consecutive_out got=%0d want=2", cap_edge[2] - cap_edge[0]); end
        end
        total++; if (if2.busy !== 1'b0) begin bad++; $display("FAIL drained_busy got=%b want=0", if2.busy); end
    endtask

    task automatic test_saturation();
        int ey[2] = '{-32768, -4};
        bit es[2] = '{1'b1, 1'b0};
        stim_x = '{16383, 1};
        drive(2, 0, 1'b0);
        total++; if (cap_y.size() !== 2) begin bad++; $display("FAIL sat_count got=%0d want=2", cap_y.size()); end
        for (int i = 0; i < 2 && i < cap_y.size(); i++) begin
            total++; if (cap_y[i] !== ey[i]) begin bad++; $display("FAIL sat_y[%0d] got=%0d want=%0d", i, cap_y[i], ey[i]); end
            total++; if (cap_sat[i] !== es[i]) begin bad++; $display("FAIL sat_flag[%0d] got=%b want=%b", i, cap_sat[i], es[i]); end
        end
    endtask

    task automatic test_backpressure();
        int ey[3] = '{-4, -13, -30};
        stim_x = '{1, 2, 3};
        drive(2, 5, 1'b0);
        total++; if (cap_y.size() !== 3) begin bad++; $display("FAIL bp_count got=%0d want=3", cap_y.size()); end
        for (int i = 0; i < 3 && i < cap_y.size(); i++) begin
            total++; if (cap_y[i] !== ey[i]) begin bad++; $display("FAIL bp_y[%0d] got=%0d want=%0d", i, cap_y[i], ey[i]); end
        end
        total++; if (stall_y.size() !== 5) begin bad++; $display("FAIL bp_stall_len got=%0d want=5", stall_y.size()); end
        for (int i = 0; i < stall_y.size(); i++) begin
            total++; if (stall_y[i] !== -4) begin bad++; $display("FAIL bp_hold_y[%0d] got=%0d want=-4", i, stall_y[i]); end
            total++; if (stall_ir[i] !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got=1 want=0", i); end
        end
    endtask

    task automatic test_random2(input string tag, input int n);
        int yv; bit sv;
        stim_x.delete(); exp_y.delete(); exp_s.delete();
        for (int i = 0; i < n; i++) begin
            stim_x.push_back(int'($urandom_range(0, 32767)) - 16384);
            ref_eval(stim_x[i], mc2, 2, 15, yv, sv);
            exp_y.push_back(yv); exp_s.push_back(sv);
        end
        drive(2, 0, 1'b1);
        total++; if (cap_y.size() !== n) begin bad++; $display("FAIL %s_count got=%0d want=%0d", tag, cap_y.size(), n); end
        for (int i = 0; i < n && i < cap_y.size(); i++) begin
            total++; if (cap_y[i] !== exp_y[i] || cap_sat[i] !== exp_s[i]) begin
                bad++; $display("FAIL %s[%0d] x=%0d got=%0d/%b want=%0d/%b", tag, i, stim_x[i], cap_y[i], cap_sat[i], exp_y[i], exp_s[i]);
            end
        end
    endtask

    task automatic wait_out2(input string tag, input int want);
        int k = 0;
        while (if2.out_valid !== 1'b1 && k < 20) begin @(posedge CLK); #1; k++; end
        total++; if (if2.out_valid !== 1'b1 || $signed(if2.y) !== want) begin
            bad++; $display("FAIL %s got=%0d valid=%b want=%0d", tag, $signed(if2.y), if2.out_valid, want);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_coef_write();
        write_coef(2, 2, 1);
        write_coef(2, 1, 0);
        write_coef(2, 0, 0);
        stim_x = '{-7};
        drive(2, 0, 1'b0);
        total++; if (cap_y.size() !== 1 || cap_y[0] !== 49) begin bad++; $display("FAIL coef_square got=%0d want=49", (cap_y.size() > 0) ? cap_y[0] : 99999); end
        set_in(2, 1'b1, 2, 1'b1);
        @(posedge CLK); #1;
        set_in(2, 1'b0, 0, 1'b1);
        if2.coef_we = 1'b1; if2.coef_addr = 3'd2; if2.coef_wdata = 15'sd5;
        #1;
        total++; if (if2.busy !== 1'b1) begin bad++; $display("FAIL busy_during_flight got=%b want=1", if2.busy); end
        total++; if (if2.in_ready !== 1'b1) begin bad++; $display("FAIL busy_write_in_ready got=%b want=1", if2.in_ready); end
        @(posedge CLK); #1;
        if2.coef_we = 1'b0;
        wait_out2("busy_write_y", 4);
        stim_x = '{3};
        drive(2, 0, 1'b0);
        total++; if (cap_y.size() !== 1 || cap_y[0] !== 9) begin bad++; $display("FAIL busy_write_dropped got=%0d want=9", (cap_y.size() > 0) ? cap_y[0] : 99999); end
    endtask

    task automatic test_collision();
        if2.coef_we = 1'b1; if2.coef_addr = 3'd0; if2.coef_wdata = 15'sd5;
        set_in(2, 1'b1, 3, 1'b1);
        #1;
        total++; if (if2.in_ready !== 1'b0) begin bad++; $display("FAIL collide_in_ready got=%b want=0", if2.in_ready); end
        @(posedge CLK); #1;
        if2.coef_we = 1'b0;
        mc2[0] = 5;
        #1;
        total++; if (if2.in_ready !== 1'b1) begin bad++; $display("FAIL collide_release got=%b want=1", if2.in_ready); end
        @(posedge CLK); #1;
        set_in(2, 1'b0, 0, 1'b1);
        wait_out2("collide_y", 14);
        write_coef(2, 3, 100);
        stim_x = '{2};
        drive(2, 0, 1'b0);
        total++; if (cap_y.size() !== 1 || cap_y[0] !== 9) begin bad++; $display("FAIL bad_addr_write got=%0d want=9", (cap_y.size() > 0) ? cap_y[0] : 99999); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            set_in(2, 1'b1, int'($urandom_range(1, 200)), 1'b1);
            @(posedge CLK); #1;
        end
        set_in(2, 1'b0, 0, 1'b1);
        #1;
        total++; if (if2.busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b want=1", if2.busy); end
        RST_N = 1'b0;
        #1;
        total++; if (if2.out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b want=0", if2.out_valid); end
        total++; if (if2.busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", if2.busy); end
        total++; if (if2.y !== '0) begin bad++; $display("FAIL mid_y got=%0d want=0", $signed(if2.y)); end
        @(posedge CLK); #1;
        RST_N = 1'b1;
        set_defaults();
        stim_x = '{2};
        drive(2, 0, 1'b0);
        total++; if (cap_y.size() !== 1 || cap_y[0] !== -13) begin bad++; $display("FAIL mid_defaults got=%0d want=-13", (cap_y.size() > 0) ? cap_y[0] : 99999); end
    endtask

    task automatic test_order4();
        int yv; bit sv;
        stim_x = '{3, 127};
        drive(4, 0, 1'b0);
        total++; if (cap_y.size() !== 2) begin bad++; $display("FAIL o4_count got=%0d want=2", cap_y.size()); end
        if (cap_y.size() == 2) begin
            total++; if (cap_y[0] !== -30 || cap_sat[0] !== 1'b0) begin bad++; $display("FAIL o4_y0 got=%0d/%b want=-30/0", cap_y[0], cap_sat[0]); end
            total++; if (cap_y[1] !== -256 || cap_sat[1] !== 1'b1) begin bad++; $display("FAIL o4_y1 got=%0d/%b want=-256/1", cap_y[1], cap_sat[1]); end
            total++; if (cap_edge[0] - acc_edge[0] !== 5) begin bad++; $display("FAIL latency4 got=%0d want=5", cap_edge[0] - acc_edge[0]); end
        end
        for (int w = 0; w < 6; w++) write_coef(4, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)) - 128);
        stim_x.delete(); exp_y.delete(); exp_s.delete();
        for (int i = 0; i < 30; i++) begin
            stim_x.push_back(int'($urandom_range(0, 255)) - 128);
            ref_eval(stim_x[i], mc4, 4, 8, yv, sv);
            exp_y.push_back(yv); exp_s.push_back(sv);
        end
        drive(4, 0, 1'b1);
        total++; if (cap_y.size() !== 30) begin bad++; $display("FAIL o4_rand_count got=%0d want=30", cap_y.size()); end
        for (int i = 0; i < 30 && i < cap_y.size(); i++) begin
            total++; if (cap_y[i] !== exp_y[i] || cap_sat[i] !== exp_s[i]) begin
                bad++; $display("FAIL o4_rand[%0d] x=%0d got=%0d/%b want=%0d/%b", i, stim_x[i], cap_y[i], cap_sat[i], exp_y[i], exp_s[i]);
            end
        end
    endtask

    initial begin
        set_in(2, 1'b0, 0, 1'b1);
        set_in(4, 1'b0, 0, 1'b1);
        if2.coef_we = 1'b0; if2.coef_addr = '0; if2.coef_wdata = '0;
        if4.coef_we = 1'b0; if4.coef_addr = '0; if4.coef_wdata = '0;
        set_defaults();
        test_reset();
        test_defaults();
        test_saturation();
        test_backpressure();
        test_random2("rand_default", 40);
        test_coef_write();
        test_collision();
        for (int a = 0; a <= 2; a++) write_coef(2, a, int'($urandom_range(0, 32767)) - 16384);
        test_random2("rand_coef", 30);
        for (int a = 0; a <= 2; a++) write_coef(2, a, int'($urandom_range(0, 40)) - 20);
        test_random2("rand_small_coef", 30);
        test_reset_mid();
        test_order4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/poly_eval_pipe.md
# poly_eval_pipe

Pipelined, parametrised signed polynomial evaluator. Computes y = c[ORDER]·x^ORDER + … + c[1]·x + c[0] by Horner's method, one Horner step per pipeline stage. It generalises the fixed-coefficient quadratic datapath to any degree from 1 to 4, with runtime-programmable coefficients, valid/ready flow control and saturating arithmetic. It sits between a sample source and any downstream consumer in the processor datapath.

## Interface
- WL, 15: signed width of x and of each coefficient.
- ORDER, 2: polynomial degree. Legal range is 1..4; elaboration fails outside it.
- ACC_W, 2*WL: signed width of the inter-stage accumulator.
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous, active-low reset.
- in_valid  in  1  x is presented.
- in_ready  out  1  x is accepted when in_valid && in_ready.
- x  in  WL  signed operand.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- y  out  WL+1  signed result, saturated.
- out_sat  out  1  y or an intermediate value was clipped; qualified by out_valid.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  3  coefficient index, 0..ORDER.
- coef_wdata  in  WL  signed coefficient value.
- busy  out  1  at least one stage holds a valid sample.

## Operation
- **Coefficient reset defaults:** c0 = -3, c1 = 3, c2 = -4. All higher coefficients are 0.
- **Coefficient writes:** accepted only when busy = 0. A write is ignored if coef_addr > ORDER.
- **Write vs. input collision:** when coef_we && !busy, in_ready = 0 that cycle. The write has priority and the input waits.
- **Ignored writes while busy:** coef_we while busy = 1 is silently dropped, with no side effects.
- **Stage 0 (input register):** captures x and sets acc = sext(c[ORDER]) to ACC_W.
- **Stage k, k = 1..ORDER:**
  - acc_k = sat_ACC(acc_{k-1} · x + sext(c[ORDER-k])).
  - The product is computed at full width, ACC_W+WL bits.
  - x is carried down the pipeline alongside acc.
- **Output stage:** y = sat_{WL+1}(acc_ORDER).
  - Saturation clamps to the most positive or most negative representable value.
- **Sticky saturation flag:** a per-sample sticky bit travels down the pipeline and is ORed at every saturation point. It appears on out_sat.
- **Flow control:**
  - Global enable: en = !out_valid || out_ready.
  - All stages advance on en.
  - in_ready = en && !(coef_we && !busy).
  - Valid bits shift through stages in lock step. Bubbles are preserved; there is no compaction.
- **Reset:** asynchronous assertion clears every valid bit, out_valid, y, out_sat and all accumulators to 0, and restores the coefficient defaults.
  - In-flight samples are discarded.
  - Deassertion is synchronised externally. The first acceptance is possible on the first CLK edge after deassertion.

## Timing
- **Latency:** a sample accepted at edge t presents out_valid at edge t+ORDER+1. For ORDER = 2 the latency is 3.
- **Throughput:** 1 sample per cycle while out_ready = 1.
- **Backpressure:** with out_valid && !out_ready, the pipeline freezes and in_ready = 0 in the same cycle (combinational). y and out_sat hold stable until the handshake completes.
- **Simultaneous events:** out handshake and in acceptance in one cycle are legal. The pipeline shifts by exactly one.
- **busy:** the OR of all stage valid bits, including out_valid, taken from registers.
- **Coefficient updates:** take effect on the first sample accepted after the write edge.
- **Output registering:** out_valid, y and out_sat are registered. in_ready is combinational from out_valid, out_ready, coef_we and busy.

## Structure
- **Shared package poly_pkg:**
  - sat function (signed saturate from N to M bits, returning a clip flag).
  - Default coefficient constants COEF_DEF[0..4] = {-3, 3, -4, 0, 0}.
  - ORDER_MAX = 4.
- **Sub-module poly_horner_stage:** one multiply, add, saturate and register slice.
  - Parameters: WL, ACC_W.
  - Ports: acc_in, x_in, coef, sat_in, vld_in, en → registered outputs.
- **Top-level:** poly_eval_pipe instantiates ORDER poly_horner_stage slices via a generate loop. It also holds the coefficient register file and the handshake logic.

## Test plan
- **Reset defaults, ORDER = 2:** drive x = 2, 0, -1 back to back with out_ready = 1.
  - Required: y = -13, -3, -10 on 3 consecutive cycles starting 3 cycles after the first acceptance.
  - out_sat = 0 throughout.
- **Saturation:** x = 16383 → y = -32768, out_sat = 1. Then x = 1 → y = -4, out_sat = 0.
- **Backpressure:** stream x = 1, 2, 3 while holding out_ready = 0 for 5 cycles after the first out_valid.
  - Required: in_ready = 0 while stalled, y stays at -4 throughout the stall.
  - After release: -4, -13, -30 in order, nothing lost or duplicated.
- **Coefficient write:**
  - While idle, write c2 = 1, c1 = 0, c0 = 0, then x = -7 → y = 49.
  - A write issued while busy is ignored. Next x = 2 → y = 4.
  - A simultaneous coef_we and in_valid while idle drops in_ready for that one cycle.
- **Reset mid-operation:** assert RST_N = 0 with 3 samples in flight.
  - Required: out_valid = 0, busy = 0, y = 0 immediately.
  - Coefficients back to defaults, so x = 2 → y = -13.
- **ORDER = 4, WL = 8, defaults:**
  - x = 3 → y = -4·9 + 9 - 3 = -30.
  - Latency is 5 cycles.
  - x = 127 → y = -256 (WL+1 = 9-bit minimum), out_sat = 1.
